// File: rtl/mask_bbox_if.sv
// Mask pixel stream in, per-frame bounding box and status out.
interface mask_bbox_if;
    logic        iEN;
    logic        iFRAME_START;
    logic        iPIX_VALID;
    logic [9:0]  iMASK;
    logic [9:0]  oX1;
    logic [9:0]  oY1;
    logic [9:0]  oX2;
    logic [9:0]  oY2;
    logic        oRet;
    logic [18:0] oPIX_CNT;
    logic        oFRAME_DONE;

    modport master (
        output iEN, iFRAME_START, iPIX_VALID, iMASK,
        input  oX1, oY1, oX2, oY2, oRet, oPIX_CNT, oFRAME_DONE
    );
    modport slave (
        input  iEN, iFRAME_START, iPIX_VALID, iMASK,
        output oX1, oY1, oX2, oY2, oRet, oPIX_CNT, oFRAME_DONE
    );
endinterface

// File: rtl/mask_bbox_tracker.sv
// Per-frame bounding box of white mask pixels with count threshold, frame
// hysteresis and margin-expanded output in VGA counter coordinates.
module mask_bbox_tracker #(
    parameter int ACT_W      = 640,
    parameter int ACT_H      = 480,
    parameter int X_OFFSET   = 144,
    parameter int Y_OFFSET   = 35,
    parameter int MARGIN     = 8,
    parameter int MIN_PIXELS = 2000,
    parameter int HOLD       = 3,
    parameter int MISS       = 4
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    mask_bbox_if.slave  bus
);
    typedef enum logic [1:0] {WAIT_SOF, ACCUM, COMMIT} state_t;

    localparam logic [9:0] XLAST = 10'(ACT_W - 1);
    localparam logic [8:0] YLAST = 9'(ACT_H - 1);

    state_t      state_q, state_d;
    logic [9:0]  x_q, x_d, min_x_q, min_x_d, max_x_q, max_x_d;
    logic [8:0]  y_q, y_d, min_y_q, min_y_d, max_y_q, max_y_d;
    logic [18:0] cnt_q, cnt_d, pix_cnt_q, pix_cnt_d;
    logic [2:0]  hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    logic [9:0]  x1_q, x1_d, y1_q, y1_d, x2_q, x2_d, y2_q, y2_d;
    logic        ret_q, ret_d, done_q, done_d;
    logic        start, acc, white, hit;
    logic [9:0]  px;
    logic [8:0]  py;
    logic [11:0] lo_x, lo_y, hi_x, hi_y;

    // Clamp in 12 bits so min-MARGIN never wraps and max+MARGIN never overflows.
    always_comb begin
        lo_x = (12'(min_x_q) >= 12'(MARGIN)) ? 12'(min_x_q) - 12'(MARGIN) : 12'd0;
        lo_y = (12'(min_y_q) >= 12'(MARGIN)) ? 12'(min_y_q) - 12'(MARGIN) : 12'd0;
        hi_x = 12'(max_x_q) + 12'(MARGIN);
        hi_y = 12'(max_y_q) + 12'(MARGIN);
        if (hi_x > 12'(ACT_W - 1)) hi_x = 12'(ACT_W - 1);
        if (hi_y > 12'(ACT_H - 1)) hi_y = 12'(ACT_H - 1);
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        cnt_d      = cnt_q;
        min_x_d    = min_x_q;
        min_y_d    = min_y_q;
        max_x_d    = max_x_q;
        max_y_d    = max_y_q;
        pix_cnt_d  = pix_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        x1_d       = x1_q;
        y1_d       = y1_q;
        x2_d       = x2_q;
        y2_d       = y2_q;
        ret_d      = ret_q;
        done_d     = 1'b0;
        hit        = 1'b0;
        px         = x_q;
        py         = y_q;
        start      = bus.iFRAME_START && bus.iEN;
        white      = (bus.iMASK == 10'h3FF);

        case (state_q)
            WAIT_SOF: if (start) state_d = ACCUM;
            ACCUM:    if (bus.iFRAME_START) state_d = bus.iEN ? ACCUM : WAIT_SOF;
            default: begin
                state_d   = start ? ACCUM : WAIT_SOF;
                hit       = (cnt_q >= 19'(MIN_PIXELS));
                pix_cnt_d = cnt_q;
                done_d    = 1'b1;
                if (hit) begin
                    hit_cnt_d  = (hit_cnt_q == 3'd7) ? 3'd7 : hit_cnt_q + 3'd1;
                    miss_cnt_d = 3'd0;
                    x1_d = 10'(lo_x + 12'(X_OFFSET));
                    x2_d = 10'(hi_x + 12'(X_OFFSET));
                    y1_d = 10'(lo_y + 12'(Y_OFFSET));
                    y2_d = 10'(hi_y + 12'(Y_OFFSET));
                    if (hit_cnt_d >= 3'(HOLD)) ret_d = 1'b1;
                end else begin
                    miss_cnt_d = (miss_cnt_q == 3'd7) ? 3'd7 : miss_cnt_q + 3'd1;
                    hit_cnt_d  = 3'd0;
                    if (miss_cnt_d >= 3'(MISS)) ret_d = 1'b0;
                end
            end
        endcase

        // A frame start (also a mid-frame one) discards whatever was accumulated.
        if (start) begin
            x_d     = '0;
            y_d     = '0;
            cnt_d   = '0;
            min_x_d = '1;
            min_y_d = '1;
            max_x_d = '0;
            max_y_d = '0;
            px      = '0;
            py      = '0;
        end

        acc = bus.iPIX_VALID && (start || (state_q == ACCUM && !bus.iFRAME_START));
        if (acc) begin
            if (white) begin
                if (px < min_x_d) min_x_d = px;
                if (px > max_x_d) max_x_d = px;
                if (py < min_y_d) min_y_d = py;
                if (py > max_y_d) max_y_d = py;
                if (cnt_d != '1) cnt_d = cnt_d + 19'd1;
            end
            x_d = (px == XLAST) ? 10'd0 : px + 10'd1;
            y_d = (px == XLAST) ? py + 9'd1 : py;
            if (px == XLAST && py == YLAST) state_d = COMMIT;
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q    <= WAIT_SOF;
            x_q        <= '0;
            y_q        <= '0;
            cnt_q      <= '0;
            min_x_q    <= '1;
            min_y_q    <= '1;
            max_x_q    <= '0;
            max_y_q    <= '0;
            pix_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            x1_q       <= '0;
            y1_q       <= '0;
            x2_q       <= '0;
            y2_q       <= '0;
            ret_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            cnt_q      <= cnt_d;
            min_x_q    <= min_x_d;
            min_y_q    <= min_y_d;
            max_x_q    <= max_x_d;
            max_y_q    <= max_y_d;
            pix_cnt_q  <= pix_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            x1_q       <= x1_d;
            y1_q       <= y1_d;
            x2_q       <= x2_d;
            y2_q       <= y2_d;
            ret_q      <= ret_d;
            done_q     <= done_d;
        end
    end

    assign bus.oX1         = x1_q;
    assign bus.oY1         = y1_q;
    assign bus.oX2         = x2_q;
    assign bus.oY2         = y2_q;
    assign bus.oRet        = ret_q;
    assign bus.oPIX_CNT    = pix_cnt_q;
    assign bus.oFRAME_DONE = done_q;
endmodule
